uart_alu_if: RTL and testbench

//  Client-side consumer of the UART block: pops bytes from the UART RX FIFO, assembles

---
 rtl/uart_alu_if.sv | 136 +++++++++++++
 tb/tb_uart_alu_if.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_if.sv
// uart_alu_if
//   Pulls bytes from the UART RX FIFO and assembles them into {A, B, OP} frames.
//   It presents each frame to an external combinational ALU, then pushes the
//   8-bit result into the UART TX FIFO. A partial frame is dropped if the RX
//   side stays quiet for TIMEOUT cycles in the middle of a frame.
//
// Ports
//   i_clk, i_reset      system clock, synchronous active-high reset
//   i_rx_empty          RX FIFO empty flag
//   i_r_data            RX FIFO head byte
//   o_rd_uart           RX FIFO pop strobe; the byte is captured on the same edge
//   i_tx_full           TX FIFO full flag
//   o_wr_uart           TX FIFO push strobe
//   o_w_data            byte pushed into the TX FIFO (the registered result)
//   o_a, o_b, o_op      registered operands and opcode driven to the ALU
//   i_alu_result        combinational ALU result
//   o_timeout           one-cycle pulse when a partial frame is discarded
//
// state  | meaning
// -------+----------------------------------------------------------
// S_A    | idle, waiting for operand A (no timeout here)
// S_B    | waiting for operand B, inter-byte timer running
// S_OP   | waiting for opcode byte, inter-byte timer running
// S_EXEC | one cycle: latch ALU result
// S_SEND | push result into TX FIFO, wait while it is full

module uart_alu_if #(
    parameter int DBIT    = 8,
    parameter int OP_BITS = 6,
    parameter int TIMEOUT = 1000000,
    parameter int TO_BITS = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_empty,
    input  logic [DBIT-1:0]    i_r_data,
    output logic               o_rd_uart,
    input  logic               i_tx_full,
    output logic               o_wr_uart,
    output logic [DBIT-1:0]    o_w_data,
    output logic [DBIT-1:0]    o_a,
    output logic [DBIT-1:0]    o_b,
    output logic [OP_BITS-1:0] o_op,
    input  logic [DBIT-1:0]    i_alu_result,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SEND = 3'd4
    } state_t;

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);
    localparam logic [TO_BITS-1:0] TO_ONE  = TO_BITS'(1);

    state_t              state;
    state_t              state_nxt;
    logic [DBIT-1:0]     a_q;
    logic [DBIT-1:0]     b_q;
    logic [OP_BITS-1:0]  op_q;
    logic [DBIT-1:0]     result_q;
    logic [TO_BITS-1:0]  to_cnt;
    logic [TO_BITS-1:0]  to_cnt_nxt;
    logic                timeout_q;
    logic                timeout_nxt;
    logic                rd;
    logic                wr;

    // The counter defaults to zero, so it clears itself in every state and
    // on every captured byte. It only advances while a mid-frame wait is idle.
    always_comb begin
        state_nxt   = state;
        rd          = 1'b0;
        wr          = 1'b0;
        to_cnt_nxt  = '0;
        timeout_nxt = 1'b0;
        case (state)
            S_A: begin
                rd = ~i_rx_empty;
                if (rd) state_nxt = S_B;
            end
            S_B, S_OP: begin
                rd = ~i_rx_empty;
                // An arriving byte takes priority over expiry in the same cycle.
                if (rd) begin
                    state_nxt = (state == S_B) ? S_OP : S_EXEC;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt   = S_A;
                    timeout_nxt = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + TO_ONE;
                end
            end
            S_EXEC: state_nxt = S_SEND;
            S_SEND: begin
                wr = ~i_tx_full;
                if (wr) state_nxt = S_A;
            end
            default: state_nxt = S_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            result_q  <= '0;
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            to_cnt    <= to_cnt_nxt;
            timeout_q <= timeout_nxt;
            if (rd && state == S_A) a_q <= i_r_data;
            if (rd && state == S_B) b_q <= i_r_data;
            if (rd && state == S_OP) op_q <= i_r_data[OP_BITS-1:0];
            if (state == S_EXEC) result_q <= i_alu_result;
        end
    end

    // Strobes are combinational, so they are masked while reset is asserted
    // to keep the FIFOs untouched during reset.
    assign o_rd_uart = rd & ~i_reset;
    assign o_wr_uart = wr & ~i_reset;
    assign o_w_data  = result_q;
    assign o_a       = a_q;
    assign o_b       = b_q;
    assign o_op      = op_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_uart_alu_if.sv
module tb_uart_alu_if;

    localparam int DBIT    = 8;
    localparam int OP_BITS = 6;
    localparam int TIMEOUT = 16;
    localparam int TO_BITS = 5;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_rx_empty = 1'b1;
    logic [DBIT-1:0]    i_r_data = '0;
    logic               i_tx_full = 1'b0;
    logic [DBIT-1:0]    i_alu_result;
    logic               o_rd_uart;
    logic               o_wr_uart;
    logic [DBIT-1:0]    o_w_data;
    logic [DBIT-1:0]    o_a;
    logic [DBIT-1:0]    o_b;
    logic [OP_BITS-1:0] o_op;
    logic               o_timeout;

    uart_alu_if #(
        .DBIT(DBIT), .OP_BITS(OP_BITS), .TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_empty(i_rx_empty), .i_r_data(i_r_data), .o_rd_uart(o_rd_uart),
        .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
        .o_a(o_a), .o_b(o_b), .o_op(o_op),
        .i_alu_result(i_alu_result), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // External ALU: ADD for opcode 0x20, XOR otherwise.
    assign i_alu_result = (o_op == 6'h20) ? (o_a + o_b) : (o_a ^ o_b);

    logic [7:0] rx_q[$];
    logic [7:0] sb_q[$];
    int         rd_cyc_q[$];
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int to_seen = 0;
    int last_rd_cyc = 0;
    int last_wr_cyc = 0;
    int last_to_cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit rd_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RX FIFO model: a pop seen at the negedge is applied just after the next edge.
    always @(posedge i_clk) begin
        cyc++;
        #1;
        if (rd_seen && rx_q.size() != 0) void'(rx_q.pop_front());
        i_rx_empty = (rx_q.size() == 0);
        i_r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    end

    // Monitor and scoreboard.
    always @(negedge i_clk) begin
        rd_seen = o_rd_uart;
        if (o_rd_uart) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            rd_cyc_q.push_back(cyc);
        end
        if (o_wr_uart) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wr_unexpected: got w_data=%0h expected no write", o_w_data);
            end else begin
                chk("w_data", o_w_data, sb_q.pop_front());
            end
        end
        if (o_timeout) begin
            to_seen++;
            last_to_cyc = cyc;
        end
    end

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                              input logic [7:0] res);
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_q.push_back(opb);
        sb_q.push_back(res);
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while ((rx_q.size() != 0 || sb_q.size() != 0) && i < budget) begin
            @(negedge i_clk);
            i++;
        end
        #1;
        chk("drain", rx_q.size() + sb_q.size(), 0);
    endtask

    task automatic wait_rd(input int target, input int budget);
        int i = 0;
        while (rd_cnt < target && i < budget) begin
            @(negedge i_clk);
            i++;
        end
        #1;
        chk("rd_reached", (rd_cnt >= target) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] op;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int rd0, wr0, a_cyc, drop_cyc;

        vecs[0] = '{a: 8'h05, b: 8'h03, opb: 8'h20, op: 6'h20, res: 8'h08};
        vecs[1] = '{a: 8'hFF, b: 8'h01, opb: 8'h20, op: 6'h20, res: 8'h00};
        vecs[2] = '{a: 8'h80, b: 8'h90, opb: 8'hE0, op: 6'h20, res: 8'h10};
        vecs[3] = '{a: 8'h3C, b: 8'h0F, opb: 8'h05, op: 6'h05, res: 8'h33};
        vecs[4] = '{a: 8'hAA, b: 8'h55, opb: 8'h3F, op: 6'h3F, res: 8'hFF};

        // Reset held for two cycles.
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        chk("rst_a", o_a, 0);
        chk("rst_b", o_b, 0);
        chk("rst_op", o_op, 0);
        chk("rst_w_data", o_w_data, 0);
        chk("rst_rd", o_rd_uart, 0);
        chk("rst_wr", o_wr_uart, 0);
        chk("rst_timeout", o_timeout, 0);
        @(posedge i_clk);
        #1 i_reset = 1'b0;

        // Table-driven frames.
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            push_frame(vecs[k].a, vecs[k].b, vecs[k].opb, vecs[k].res);
            wait_drain(40);
            chk("vec_a", o_a, vecs[k].a);
            chk("vec_b", o_b, vecs[k].b);
            chk("vec_op", o_op, vecs[k].op);
            chk("vec_rd_count", rd_cnt - rd0, 3);
            chk("vec_wr_count", wr_cnt - wr0, 1);
            chk("vec_latency", last_wr_cyc - last_rd_cyc, 2);
        end

        // TX backpressure: no pushes and no pops while the TX FIFO is full.
        @(posedge i_clk);
        #1 i_tx_full = 1'b1;
        @(negedge i_clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        push_frame(8'h05, 8'h03, 8'h20, 8'h08);
        push_frame(8'h01, 8'h02, 8'h20, 8'h03);
        wait_rd(rd0 + 3, 20);
        repeat (10) @(negedge i_clk);
        #1;
        chk("full_no_wr", wr_cnt - wr0, 0);
        chk("full_no_rd", rd_cnt - rd0, 3);
        @(posedge i_clk);
        #1 i_tx_full = 1'b0;
        drop_cyc = cyc;
        @(negedge i_clk);
        #1;
        chk("full_release_wr", wr_cnt - wr0, 1);
        chk("full_release_cyc", last_wr_cyc, drop_cyc);
        wait_drain(40);
        chk("full_total_wr", wr_cnt - wr0, 2);

        // Inter-byte timeout after operand A only.
        @(negedge i_clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        to_seen = 0;
        rx_q.push_back(8'h05);
        wait_rd(rd0 + 1, 10);
        a_cyc = last_rd_cyc;
        for (int i = 0; i < 40 && to_seen == 0; i++) @(negedge i_clk);
        #1;
        chk("to_pulse", to_seen, 1);
        chk("to_delay", last_to_cyc - a_cyc, TIMEOUT + 1);
        chk("to_stale_a", o_a, 8'h05);
        @(negedge i_clk);
        #1;
        chk("to_width", to_seen, 1);
        chk("to_no_wr", wr_cnt - wr0, 0);
        push_frame(8'h01, 8'h02, 8'h20, 8'h03);
        wait_drain(40);
        chk("to_next_a", o_a, 8'h01);
        chk("to_next_wr", wr_cnt - wr0, 1);

        // Two frames preloaded back to back.
        @(negedge i_clk);
        rd_cyc_q.delete();
        push_frame(8'h05, 8'h03, 8'h20, 8'h08);
        push_frame(8'h01, 8'h02, 8'h20, 8'h03);
        wait_drain(60);
        chk("b2b_rd_count", rd_cyc_q.size(), 6);
        if (rd_cyc_q.size() == 6) begin
            chk("b2b_f1_gap1", rd_cyc_q[1] - rd_cyc_q[0], 1);
            chk("b2b_f1_gap2", rd_cyc_q[2] - rd_cyc_q[1], 1);
            chk("b2b_frame_gap", rd_cyc_q[3] - rd_cyc_q[2], 3);
            chk("b2b_f2_gap1", rd_cyc_q[4] - rd_cyc_q[3], 1);
            chk("b2b_f2_gap2", rd_cyc_q[5] - rd_cyc_q[4], 1);
        end

        // Reset after A and B captured: partial frame is dropped.
        @(negedge i_clk);
        rd0 = rd_cnt;
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        wait_rd(rd0 + 2, 10);
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        #1;
        chk("mid_rst_a", o_a, 0);
        chk("mid_rst_b", o_b, 0);
        wr0 = wr_cnt;
        push_frame(8'h07, 8'h01, 8'h20, 8'h08);
        wait_drain(40);
        chk("mid_rst_new_a", o_a, 8'h07);
        chk("mid_rst_new_b", o_b, 8'h01);
        chk("mid_rst_wr", wr_cnt - wr0, 1);

        repeat (5) @(negedge i_clk);
        #1;
        chk("final_sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
